// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request/response tracking, 2-entry output FIFO
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr   word-aligned fetch request handshake
//   imem_resp_valid, imem_resp_data   in-order instruction responses
//   redirect_valid, redirect_pc       taken branch/jump; flushes buffered and in-flight fetches
//   if_valid/ready, if_instr, if_pc   instruction and its PC toward decode
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   logic [31:0] pc_q;
   logic [1:0]  live_cnt;
   logic [1:0]  kill_cnt;
   logic [1:0]  buf_cnt;

   // Tag FIFO: PCs of live in-flight requests, in issue order.
   logic [31:0] tag_mem [2];
   logic        tag_wr;
   logic        tag_rd;

   // Output FIFO toward decode; the head entry drives if_instr/if_pc directly.
   logic [31:0] out_instr [2];
   logic [31:0] out_pc [2];
   logic        out_wr;
   logic        out_rd;

   logic        pop;
   logic        credit_ok;
   logic        accept;
   logic        resp_kill;
   logic        resp_live;
   logic [2:0]  kill_sum;
   logic [1:0]  kill_redirect;

   assign if_valid  = (buf_cnt != 2'd0);
   assign if_instr  = out_instr[out_rd];
   assign if_pc     = out_pc[out_rd];
   assign imem_addr = pc_q;

   assign pop = if_valid & if_ready;

   // Outstanding requests (live + killed) are capped at two, and every live
   // request must already own a slot in the output FIFO so a response can
   // always be absorbed.
   assign credit_ok = (({1'b0, live_cnt} + {1'b0, kill_cnt}) < 3'd2) &
                      (({1'b0, live_cnt} + {1'b0, buf_cnt}) < (3'd2 + {2'b00, pop}));

   assign imem_req_valid = rst_n & credit_ok & ~redirect_valid;
   assign accept         = imem_req_valid & imem_req_ready;

   // Stale responses are consumed first; a response with nothing tracked is ignored.
   assign resp_kill = imem_resp_valid & (kill_cnt != 2'd0);
   assign resp_live = imem_resp_valid & (kill_cnt == 2'd0) & (live_cnt != 2'd0);

   // On redirect every live request becomes stale, minus any response that
   // lands in the redirect cycle itself (it is dropped right away).
   always_comb begin
      kill_sum      = {1'b0, kill_cnt} + {1'b0, live_cnt};
      kill_redirect = 2'd0;
      if (imem_resp_valid && (kill_sum != 3'd0)) begin
         kill_sum = kill_sum - 3'd1;
      end
      if (kill_sum > 3'd2) begin
         kill_redirect = 2'd2;
      end else begin
         kill_redirect = kill_sum[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         live_cnt <= 2'd0;
         kill_cnt <= 2'd0;
         buf_cnt  <= 2'd0;
         tag_wr   <= 1'b0;
         tag_rd   <= 1'b0;
         out_wr   <= 1'b0;
         out_rd   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            tag_mem[i]   <= 32'd0;
            out_instr[i] <= 32'd0;
            out_pc[i]    <= 32'd0;
         end
      end else if (redirect_valid) begin
         // A pop in this cycle is satisfied by the current head; the flush
         // then discards everything, so no pointer bookkeeping is needed.
         pc_q     <= {redirect_pc[31:2], 2'b00};
         live_cnt <= 2'd0;
         kill_cnt <= kill_redirect;
         buf_cnt  <= 2'd0;
         tag_wr   <= 1'b0;
         tag_rd   <= 1'b0;
         out_wr   <= 1'b0;
         out_rd   <= 1'b0;
      end else begin
         if (accept) begin
            tag_mem[tag_wr] <= pc_q;
            tag_wr          <= ~tag_wr;
            pc_q            <= pc_q + 32'd4;
         end
         if (resp_kill) begin
            kill_cnt <= kill_cnt - 2'd1;
         end
         if (resp_live) begin
            out_instr[out_wr] <= imem_resp_data;
            out_pc[out_wr]    <= tag_mem[tag_rd];
            out_wr            <= ~out_wr;
            tag_rd            <= ~tag_rd;
         end
         if (pop) begin
            out_rd <= ~out_rd;
         end
         live_cnt <= live_cnt + {1'b0, accept} - {1'b0, resp_live};
         buf_cnt  <= buf_cnt + {1'b0, resp_live} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based fetch model
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_instr        (if_instr),
      .if_pc           (if_pc)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: fetch PC, in-flight requests {stale, pc}, instructions waiting for
   // decode {instr, pc}, and the memory's pending responses {due_cycle, addr}.
   logic [31:0] m_pc;
   logic [32:0] inf_q[$];
   logic [63:0] out_q[$];
   logic [63:0] mem_q[$];
   int          cyc;
   int          lat;

   logic        chk_en;
   logic        exp_req_valid;
   logic        exp_if_valid;
   logic [31:0] exp_addr;
   logic [31:0] exp_if_instr;
   logic [31:0] exp_if_pc;
   logic        cur_redirect;
   logic        cur_resp;
   logic        cur_pop;
   logic [31:0] cur_rpc;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic logic resp_due();
      return (mem_q.size() > 0) && (mem_q[0][63:32] <= 32'(cyc));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: cycle budget expired", name);
   endtask

   task automatic model_reset();
      m_pc = RST_PC;
      inf_q.delete();
      out_q.delete();
      mem_q.delete();
      cyc = 0;
   endtask

   // Drive one cycle's inputs, derive the expected outputs, stop just after the negedge.
   task automatic drive_cycle(input logic redir, input logic [31:0] rpc,
                              input logic rdy, input logic qrdy);
      int live;
      redirect_valid  = redir;
      redirect_pc     = rpc;
      if_ready        = rdy;
      imem_req_ready  = qrdy;
      cur_redirect    = redir;
      cur_rpc         = rpc;
      cur_resp        = resp_due();
      imem_resp_valid = cur_resp;
      imem_resp_data  = cur_resp ? instr_of(mem_q[0][31:0]) : 32'hDEAD_BEEF;
      exp_if_valid    = (out_q.size() > 0);
      exp_if_instr    = exp_if_valid ? out_q[0][63:32] : 32'd0;
      exp_if_pc       = exp_if_valid ? out_q[0][31:0] : 32'd0;
      cur_pop         = exp_if_valid & rdy;
      live = 0;
      foreach (inf_q[i]) if (!inf_q[i][32]) live++;
      exp_req_valid = (inf_q.size() < 2) && ((live + out_q.size() - int'(cur_pop)) < 2) && !redir;
      exp_addr      = m_pc;
      @(negedge clk);
      #1;
   endtask

   // Advance the model by the events of the cycle just driven, then move past the next posedge.
   task automatic end_cycle();
      logic [32:0] head;
      logic [63:0] junk;
      if (cur_pop) junk = out_q.pop_front();
      if (cur_resp) begin
         junk = mem_q.pop_front();
         if (inf_q.size() > 0) begin
            head = inf_q.pop_front();
            if (!cur_redirect && !head[32]) out_q.push_back({imem_resp_data, head[31:0]});
         end
      end
      if (cur_redirect) begin
         out_q.delete();
         foreach (inf_q[i]) inf_q[i][32] = 1'b1;
         m_pc = {cur_rpc[31:2], 2'b00};
      end else if (exp_req_valid && imem_req_ready) begin
         inf_q.push_back({1'b0, m_pc});
         mem_q.push_back({32'(cyc + lat), m_pc});
         m_pc = m_pc + 32'd4;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic redir, input logic [31:0] rpc, input logic rdy, input logic qrdy);
      drive_cycle(redir, rpc, rdy, qrdy);
      end_cycle();
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
         chk("imem_addr", imem_addr, exp_addr);
         chk("if_valid", 32'(if_valid), 32'(exp_if_valid));
         if (exp_if_valid) begin
            chk("if_instr", if_instr, exp_if_instr);
            chk("if_pc", if_pc, exp_if_pc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      rst_n           = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'd0;
      if_ready        = 1'b0;
      chk_en          = 1'b0;
      cur_redirect    = 1'b0;
      cur_resp        = 1'b0;
      cur_pop         = 1'b0;
      cur_rpc         = 32'd0;
      lat             = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_addr", imem_addr, 32'h0000_0100);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Streaming at one instruction per cycle with 1-cycle memory.
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("first_req", 32'(imem_req_valid), 32'd1);
      chk("addr_c0", imem_addr, 32'h0000_0100);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("addr_c1", imem_addr, 32'h0000_0104);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("first_if_valid", 32'(if_valid), 32'd1);
      chk("first_if_pc", if_pc, 32'h0000_0100);
      chk("first_if_instr", if_instr, 32'h1357_9ADF);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("if_pc_c3", if_pc, 32'h0000_0104);
      chk("addr_c3", imem_addr, 32'h0000_010C);
      end_cycle();
      repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b1);

      // Decode stall: buffer fills to two, issue stops, then resumes with the first pop.
      drive_cycle(1'b0, 32'd0, 1'b0, 1'b1);
      chk("stall_drop", 32'(imem_req_valid), 32'd0);
      end_cycle();
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, 32'd0, 1'b0, 1'b1);
         if (i == 4) begin
            chk("stall_hold_pc", if_pc, 32'h0000_0118);
            chk("stall_full_noreq", 32'(imem_req_valid), 32'd0);
         end
         end_cycle();
      end
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("resume_req", 32'(imem_req_valid), 32'd1);
      chk("resume_addr", imem_addr, 32'h0000_0120);
      chk("resume_pc0", if_pc, 32'h0000_0118);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("resume_pc1", if_pc, 32'h0000_011C);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("resume_pc2", if_pc, 32'h0000_0120);
      end_cycle();

      // Redirect with two stale requests outstanding on a 3-cycle memory.
      lat   = 3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (inf_q.size() == 2 && !resp_due()) found = 1'b1;
         else cycle(1'b0, 32'd0, 1'b1, 1'b1);
      end
      if (!found) bound_fail("two_outstanding");
      drive_cycle(1'b1, 32'h0000_2003, 1'b1, 1'b1);
      chk("redir_noreq", 32'(imem_req_valid), 32'd0);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("redir_r1_addr", imem_addr, 32'h0000_2000);
      chk("redir_r1_blocked", 32'(imem_req_valid), 32'd0);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("redir_r2_req", 32'(imem_req_valid), 32'd1);
      end_cycle();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (out_q.size() > 0) found = 1'b1;
         else cycle(1'b0, 32'd0, 1'b1, 1'b1);
      end
      if (!found) bound_fail("redir_first_instr");
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("redir_if_pc", if_pc, 32'h0000_2000);
      chk("redir_if_instr", if_instr, 32'h1357_BBDF);
      end_cycle();

      // Redirect coinciding with a response and a pop.
      lat   = 1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (out_q.size() > 0 && inf_q.size() == 1 && resp_due()) found = 1'b1;
         else cycle(1'b0, 32'd0, 1'b1, 1'b1);
      end
      if (!found) bound_fail("resp_pop_cycle");
      drive_cycle(1'b1, 32'h0000_3000, 1'b1, 1'b1);
      chk("redir_pop_valid", 32'(if_valid), 32'd1);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("redir2_r1_req", 32'(imem_req_valid), 32'd1);
      chk("redir2_r1_addr", imem_addr, 32'h0000_3000);
      chk("redir2_r1_empty", 32'(if_valid), 32'd0);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("redir2_r2_empty", 32'(if_valid), 32'd0);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("redir2_r3_pc", if_pc, 32'h0000_3000);
      end_cycle();

      // PC wrap at the top of the address space.
      cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("wrap_addr1", imem_addr, 32'h0000_0000);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("wrap_pc0", if_pc, 32'hFFFF_FFFC);
      end_cycle();
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("wrap_pc1", if_pc, 32'h0000_0000);
      end_cycle();

      // Asynchronous reset mid-stream with a full buffer.
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (out_q.size() == 2) found = 1'b1;
         else cycle(1'b0, 32'd0, 1'b0, 1'b1);
      end
      if (!found) bound_fail("fill_before_reset");
      chk_en          = 1'b0;
      imem_resp_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_if_valid", 32'(if_valid), 32'd0);
      chk("async_req_valid", 32'(imem_req_valid), 32'd0);
      chk("async_if_pc", if_pc, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n  = 1'b1;
      chk_en = 1'b1;
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("restart_addr", imem_addr, 32'h0000_0100);
      chk("restart_req", 32'(imem_req_valid), 32'd1);
      end_cycle();
      cycle(1'b0, 32'd0, 1'b1, 1'b1);
      drive_cycle(1'b0, 32'd0, 1'b1, 1'b1);
      chk("restart_if_pc", if_pc, 32'h0000_0100);
      end_cycle();
      repeat (2) cycle(1'b0, 32'd0, 1'b1, 1'b1);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
